// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and state encoding for the PWM duty-ramp sequencer.
//   PWM_DW      default duty width (matches the PWM Din width)
//   PWM_DIVW    default step-rate divider width
//   pwm_state_e sequencer states {IDLE, RAMP}
package pwm_pkg;

    localparam int PWM_DW   = 8;
    localparam int PWM_DIVW = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_tick_div.sv
// pwm_tick_div: loadable down-counter clocked by the PWM period strobe.
// Fires a one-cycle step enable when a tick arrives while the count is 0,
// then reloads with the divider value latched at the last load.
// Ports:
//   CLK       in   system clock
//   sRSTn     in   synchronous reset, active-low
//   load_i    in   load counter and divider value (request accept)
//   div_i     in   divider value; one step per div_i+1 ticks
//   en_i      in   count ticks only while enabled (ramping)
//   tick_i    in   PWM period wrap strobe
//   step_en_o out  one-cycle step enable
module pwm_tick_div #(
    parameter int DIVW = 4
) (
    input  logic            CLK,
    input  logic            sRSTn,
    input  logic            load_i,
    input  logic [DIVW-1:0] div_i,
    input  logic            en_i,
    input  logic            tick_i,
    output logic            step_en_o
);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;

    assign step_en_o = en_i && tick_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        // Load wins over a tick in the same cycle, so a tick coinciding
        // with the accept is never counted.
        if (load_i) begin
            cnt_d = div_i;
            div_d = div_i;
        end else if (en_i && tick_i) begin
            cnt_d = (cnt_q == '0) ? div_q : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!sRSTn) begin
            cnt_q <= '0;
            div_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/pwm_duty_seq.sv
// pwm_duty_seq: duty-ramp sequencer for the 8-bit PWM generator.
// Accepts a target duty over a valid/ready handshake and slews Duty toward
// it by Step every Div+1 PWM period ticks, saturating on the target.
// Optional feature macro: PWM_SEQ_CLAMP_EN (clamps targets to DUTY_MAX).
// Handshake: a request is accepted on any rising edge where TgtValid and
// TgtReady are both 1; TgtReady depends only on state, never on TgtValid,
// and the requester holds TgtValid and its data stable until accepted.
// Ports:
//   CLK       in   system clock
//   sRSTn     in   synchronous reset, active-low
//   Tick      in   PWM period wrap strobe
//   TgtD      in   requested target duty
//   Step      in   step size (0 behaves as 1), sampled at accept
//   Div       in   step-rate divider, sampled at accept
//   TgtValid  in   target request
//   TgtReady  out  high in IDLE
//   Duty      out  registered duty word to the PWM
//   Busy      out  high in RAMP
//   Done      out  one-cycle pulse when Duty reaches the target
//   Clamp     out  one-cycle pulse when an accepted target was clamped
//   DbgState  out  current FSM state (debug observation)
module pwm_duty_seq
    import pwm_pkg::*;
#(
    parameter int DW       = PWM_DW,
    parameter int DIVW     = PWM_DIVW,
    parameter int DUTY_MAX = 255
) (
    input  logic            CLK,
    input  logic            sRSTn,
    input  logic            Tick,
    input  logic [DW-1:0]   TgtD,
    input  logic [DW-1:0]   Step,
    input  logic [DIVW-1:0] Div,
    input  logic            TgtValid,
    output logic            TgtReady,
    output logic [DW-1:0]   Duty,
    output logic            Busy,
    output logic            Done,
    output logic            Clamp,
    output logic [0:0]      DbgState
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RAMP = RAMP;

    logic [0:0]    state_q, state_d;
    logic [DW-1:0] duty_q, duty_d;
    logic [DW-1:0] tgt_q, tgt_d;
    logic [DW-1:0] step_q, step_d;
    logic          up_q, up_d;
    logic          done_q, done_d;
    logic          clamp_q, clamp_d;

    logic          accept;
    logic          step_en;
    logic [DW-1:0] tgt_in;
    logic          clamp_hit;
    logic [DW:0]   gap;

`ifdef PWM_SEQ_CLAMP_EN
    localparam logic [DW-1:0] DMAX = DW'(DUTY_MAX);
    assign clamp_hit = (TgtD > DMAX);
    assign tgt_in    = clamp_hit ? DMAX : TgtD;
`else
    assign clamp_hit = 1'b0;
    assign tgt_in    = TgtD;
`endif

    assign TgtReady = (state_q == ST_IDLE);
    assign Busy     = (state_q == ST_RAMP);
    assign Duty     = duty_q;
    assign Done     = done_q;
    assign Clamp    = clamp_q;
    assign DbgState = state_q;

    assign accept = TgtValid && TgtReady;

    pwm_tick_div #(
        .DIVW (DIVW)
    ) u_tick_div (
        .CLK       (CLK),
        .sRSTn     (sRSTn),
        .load_i    (accept),
        .div_i     (Div),
        .en_i      (Busy),
        .tick_i    (Tick),
        .step_en_o (step_en)
    );

    // Remaining distance to the target, one bit wider than Duty.
    assign gap = up_q ? ({1'b0, tgt_q} - {1'b0, duty_q})
                      : ({1'b0, duty_q} - {1'b0, tgt_q});

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        up_d    = up_q;
        done_d  = 1'b0;
        clamp_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TgtValid) begin
                    tgt_d   = tgt_in;
                    step_d  = (Step == '0) ? DW'(1) : Step;
                    up_d    = (tgt_in > duty_q);
                    clamp_d = clamp_hit;
                    if (tgt_in == duty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (step_en) begin
                    if (gap <= {1'b0, step_q}) begin
                        duty_d  = tgt_q;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        // gap > step here, so this cannot wrap in DW bits.
                        duty_d = up_q ? (duty_q + step_q) : (duty_q - step_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!sRSTn) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= DW'(1);
            up_q    <= 1'b0;
            done_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            up_q    <= up_d;
            done_q  <= done_d;
            clamp_q <= clamp_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_seq.sv
// tb_pwm_duty_seq: table-driven bench for pwm_duty_seq with a duty scoreboard.
module tb_pwm_duty_seq;

    logic       CLK = 1'b0;
    logic       sRSTn = 1'b0;
    logic       Tick = 1'b0;
    logic [7:0] TgtD = '0;
    logic [7:0] Step = '0;
    logic [3:0] Div = '0;
    logic       TgtValid = 1'b0;
    logic       TgtReady;
    logic [7:0] Duty;
    logic       Busy;
    logic       Done;
    logic       Clamp;
    logic [0:0] DbgState;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur = '0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    pwm_duty_seq #(
        .DW       (8),
        .DIVW     (4),
        .DUTY_MAX (200)
    ) dut (
        .CLK      (CLK),
        .sRSTn    (sRSTn),
        .Tick     (Tick),
        .TgtD     (TgtD),
        .Step     (Step),
        .Div      (Div),
        .TgtValid (TgtValid),
        .TgtReady (TgtReady),
        .Duty     (Duty),
        .Busy     (Busy),
        .Done     (Done),
        .Clamp    (Clamp),
        .DbgState (DbgState)
    );

`ifdef PWM_SEQ_CLAMP_EN
    localparam int F7 = 200, T7 = 8, F9 = 200, T10 = 16;
`else
    localparam int F7 = 250, T7 = 10, F9 = 255, T10 = 32;
`endif

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] step;
        logic [3:0] div;
        logic       tick_acc;
        logic [7:0] fin;
        int         ticks;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [7:0] lat_tgt(input logic [7:0] t);
`ifdef PWM_SEQ_CLAMP_EN
        return (t > 8'd200) ? 8'd200 : t;
`else
        return t;
`endif
    endfunction

    function automatic logic exp_clamp(input logic [7:0] t);
`ifdef PWM_SEQ_CLAMP_EN
        return (t > 8'd200);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic tk);
        Tick = tk;
        @(posedge CLK);
        #1;
        Tick = 1'b0;
    endtask

    // Issues one request and pushes the expected duty sequence to exp_q.
    task automatic accept(input logic [7:0] tgt, input logic [7:0] stp,
                          input logic [3:0] dv, input logic tk);
        logic [7:0] lt;
        logic [7:0] s;
        int c;
        TgtD = tgt;
        Step = stp;
        Div = dv;
        TgtValid = 1'b1;
        cycle(tk);
        TgtValid = 1'b0;
        lt = lat_tgt(tgt);
        s = (stp == 8'd0) ? 8'd1 : stp;
        check("accept_clamp", Clamp, exp_clamp(tgt));
        check("accept_duty", Duty, cur);
        if (lt == cur) begin
            check("equal_done", Done, 1'b1);
            check("equal_busy", Busy, 1'b0);
            check("equal_ready", TgtReady, 1'b1);
        end else begin
            check("accept_busy", Busy, 1'b1);
            check("accept_ready", TgtReady, 1'b0);
            check("accept_done", Done, 1'b0);
        end
        c = cur;
        while (c != lt) begin
            if (lt > c) c = (lt - c <= s) ? lt : c + s;
            else        c = (c - lt <= s) ? lt : c - s;
            exp_q.push_back(8'(c));
        end
    endtask

    // Ticks until the scoreboard drains, checking every cycle against it.
    task automatic run_ramp(input int dv, input int exp_ticks);
        int ticks = 0;
        int gap;
        logic [7:0] e;
        while (exp_q.size() > 0 && ticks < 2000) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                cycle(1'b0);
                check("gap_duty", Duty, cur);
                check("gap_done", Done, 1'b0);
            end
            cycle(1'b1);
            ticks++;
            if (ticks % (dv + 1) == 0) begin
                e = exp_q.pop_front();
                check("step_duty", Duty, e);
                check("step_done", Done, exp_q.size() == 0);
                cur = e;
            end else begin
                check("hold_duty", Duty, cur);
                check("hold_done", Done, 1'b0);
            end
        end
        if (exp_q.size() != 0) begin
            check("ramp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        check("ramp_ticks", ticks, exp_ticks);
        check("end_busy", Busy, 1'b0);
        check("end_ready", TgtReady, 1'b1);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{8'd100, 8'd10,  4'd0,  1'b0, 8'd100, 10};
        vecs[1] = '{8'd0,   8'd25,  4'd2,  1'b1, 8'd0,   12};
        vecs[2] = '{8'd100, 8'd30,  4'd0,  1'b0, 8'd100, 4};
        vecs[3] = '{8'd100, 8'd7,   4'd3,  1'b0, 8'd100, 0};
        vecs[4] = '{8'd0,   8'd255, 4'd0,  1'b0, 8'd0,   1};
        vecs[5] = '{8'd3,   8'd0,   4'd0,  1'b0, 8'd3,   3};
        vecs[6] = '{8'd250, 8'd50,  4'd1,  1'b0, 8'(F7), T7};
        vecs[7] = '{8'd0,   8'd255, 4'd0,  1'b0, 8'd0,   1};
        vecs[8] = '{8'd255, 8'd128, 4'd0,  1'b0, 8'(F9), 2};
        vecs[9] = '{8'd0,   8'd200, 4'd15, 1'b1, 8'd0,   T10};

        sRSTn = 1'b0;
        cycle(1'b0);
        cycle(1'b0);
        check("rst_duty", Duty, 8'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_clamp", Clamp, 1'b0);
        check("rst_ready", TgtReady, 1'b1);
        sRSTn = 1'b1;
        cycle(1'b0);
        check("idle_duty", Duty, 8'd0);
        cur = 8'd0;

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].tgt, vecs[i].step, vecs[i].div, vecs[i].tick_acc);
            if (exp_q.size() == 0) begin
                cycle(1'b0);
                check("equal_done_clear", Done, 1'b0);
                check("equal_stay_idle", Busy, 1'b0);
            end else begin
                run_ramp(int'(vecs[i].div), vecs[i].ticks);
            end
            check("row_final_duty", Duty, vecs[i].fin);
        end

        // Reset in mid-ramp with a request held during RAMP.
        accept(8'd100, 8'd20, 4'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1);
            cur = exp_q.pop_front();
            check("mid_duty", Duty, cur);
        end
        exp_q.delete();
        TgtD = 8'd40;
        Step = 8'd20;
        Div = 4'd0;
        TgtValid = 1'b1;
        repeat (2) begin
            cycle(1'b0);
            check("held_ready", TgtReady, 1'b0);
            check("held_duty", Duty, 8'd60);
        end
        sRSTn = 1'b0;
        cycle(1'b1);
        sRSTn = 1'b1;
        check("midrst_duty", Duty, 8'd0);
        check("midrst_busy", Busy, 1'b0);
        check("midrst_ready", TgtReady, 1'b1);
        check("midrst_done", Done, 1'b0);
        cur = 8'd0;
        accept(8'd40, 8'd20, 4'd0, 1'b0);
        run_ramp(0, 2);
        check("post_rst_final", Duty, 8'd40);
        cycle(1'b0);
        check("final_done_clear", Done, 1'b0);
        check("final_busy", Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
